alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values 8..64, even.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 a  input  WIDTH  operand A (dividend / multiplicand / move source).
REQ-007 b  input  WIDTH  operand B (divisor / multiplier).
REQ-008 flush  input  1  synchronous abort of an in-flight operation.
REQ-009 busy  output  1  high while a multi-cycle operation is in flight.
REQ-010 done  output  1  one-cycle pulse; hi/lo already hold the new result in that cycle.
REQ-011 hi  output  WIDTH  HI register (product upper half / remainder).
REQ-012 lo  output  WIDTH  LO register (product lower half / quotient).
REQ-013 div_by_zero  output  1  sticky flag for the last divide; valid while done is high and until the next accepted start.

Function
REQ-014 States: IDLE, MUL, DIV, FIX, DONE.
REQ-015 IDLE with start=1 and op MULT/MULTU: latch operand magnitudes and signs; go to MUL with step counter = 0.
REQ-016 IDLE with start=1 and op DIV/DIVU: latch operand magnitudes and signs; go to DIV with step counter = 0.
REQ-017 MUL: radix-2 shift-add, one bit per cycle, exactly WIDTH cycles, then FIX.
REQ-018 DIV: restoring shift-subtract, one quotient bit per cycle, exactly WIDTH cycles, then FIX.
REQ-019 FIX: apply two's-complement sign correction in one cycle.
  - Signed product: negate if sign(a) XOR sign(b).
  - Quotient: negate if sign(a) XOR sign(b).
  - Remainder: takes the sign of a.
  - Write hi/lo; go to DONE.
REQ-020 DONE: done=1 for one cycle, then IDLE.
REQ-021 Latency from the start-accept edge to done high is WIDTH+2 cycles.
REQ-022 busy=1 in MUL, DIV and FIX; busy=0 in IDLE and DONE.
REQ-023 start in any state other than IDLE is ignored; no queuing.
REQ-024 MTHI/MTLO with start in IDLE: load hi (or lo) from a at that edge; done pulses the next cycle; busy stays low; no state other than IDLE is entered.
REQ-025 Unused op codes with start in IDLE: no action, no done.
REQ-026 Divide by zero (b=0):
  - Full WIDTH+2 latency is kept.
  - hi = a, lo = all ones, div_by_zero = 1.
  - The FIX sign correction is skipped.
REQ-027 Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0, div_by_zero = 0.
REQ-028 flush=1 in MUL, DIV or FIX: return to IDLE next edge; hi/lo unchanged; no done.
REQ-029 flush in IDLE or DONE has no effect.
REQ-030 flush has priority over start.
REQ-031 Step counter is SHW = clog2(WIDTH)+1 bits wide; terminal count WIDTH-1; no wrap-around beyond it.
REQ-032 hi/lo change only in FIX, on MTHI/MTLO, or on reset.

Reset
REQ-033 rst_n=0 at a rising edge forces:
  - state IDLE, step counter 0;
  - hi=0, lo=0;
  - busy=0, done=0, div_by_zero=0.
  This applies in every state, including mid-operation.
REQ-034 start and flush are ignored on any edge where rst_n=0.

Structure
REQ-035 A shared package alu_mdu_pkg shall hold:
  - the op encodings MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - the state enumeration;
  - the default WIDTH constant.
REQ-036 One sub-module, alu_mdu_divstep, shall implement one combinational restoring-divide step: partial remainder, divisor -> next partial remainder, quotient bit.
REQ-037 The datapath shall use one shared WIDTH-bit adder/subtractor for MUL and DIV steps; there shall be no combinational multiplier or divider.

Verification
REQ-038 MULT, a=0xFFFFFFFF, b=4 -> done at start+34; hi=0xFFFFFFFF, lo=0xFFFFFFFC; busy high for 33 cycles.
REQ-039 MULTU, a=0xFFFFFFFF, b=4 -> hi=0x00000003, lo=0xFFFFFFFC.
REQ-040 DIV, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-041 DIVU, a=7, b=2 -> lo=3, hi=1.
REQ-042 DIVU, a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1.
REQ-043 DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-044 Start MULT, then:
  - a second start at cycle 5 is ignored;
  - flush at cycle 10 -> IDLE, no done, hi/lo unchanged;
  - a repeat run with rst_n=0 at cycle 12 -> all outputs 0 the next cycle;
  - MTHI a=0xA5A5A5A5 afterwards -> hi=0xA5A5A5A5, done one cycle later, busy never high.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes, FSM states and
// the default datapath width.
package alu_mdu_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/alu_mdu_divstep.sv
// One restoring-divide step. The subtraction itself is done by the shared adder in the top;
// this block forms its operands and decides whether the difference is kept.
module alu_mdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH:0]   add_sum,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);

  // Partial remainder is {rem, din}; its top bit rem[WIDTH-1] is handled without widening
  // the adder: if it is set the partial remainder always exceeds the divisor.
  assign add_x    = {rem[WIDTH-2:0], din};
  assign add_y    = ~divisor;
  assign qbit     = rem[WIDTH-1] | add_sum[WIDTH];
  assign next_rem = qbit ? add_sum[WIDTH-1:0] : add_x;

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle HI/LO multiply/divide unit: shift-add multiply, restoring divide, one shared
// adder, sign fix-up cycle, plus direct HI/LO moves.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned SHW = $clog2(WIDTH) + 1;

  state_e           state;
  logic [SHW-1:0]   cnt;
  // acc: product high half / partial remainder; sh: multiplier / dividend-then-quotient
  logic [WIDTH-1:0] acc, sh, opb;
  logic             sa, sb, sgn, isdiv;

  op_e              op_in;
  logic             op_signed, op_isdiv, last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] add_x, add_y, div_x, div_y, div_rem;
  logic             add_cin, div_q;
  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_in     = op_e'(op);
  assign op_signed = (op_in == OpMult) || (op_in == OpDiv);
  assign op_isdiv  = (op_in == OpDiv) || (op_in == OpDivu);
  assign last      = (cnt == SHW'(WIDTH - 1));

  alu_mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (acc),
    .din      (sh[WIDTH-1]),
    .divisor  (opb),
    .add_sum  (add_sum),
    .add_x    (div_x),
    .add_y    (div_y),
    .next_rem (div_rem),
    .qbit     (div_q)
  );

  always_comb begin
    mag_a = (op_signed && a[WIDTH-1]) ? -a : a;
    mag_b = (op_signed && b[WIDTH-1]) ? -b : b;
    if (state == StDiv) begin
      add_x   = div_x;
      add_y   = div_y;
      add_cin = 1'b1;
    end else begin
      add_x   = acc;
      add_y   = sh[0] ? opb : '0;
      add_cin = 1'b0;
    end
    add_sum  = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    prod_mag = {acc, sh};
    prod_fix = (sgn && (sa ^ sb)) ? -prod_mag : prod_mag;
    quo_fix  = (sgn && (sa ^ sb)) ? -sh : sh;
    rem_fix  = (sgn && sa) ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StIdle;
      cnt         <= '0;
      acc         <= '0;
      sh          <= '0;
      opb         <= '0;
      {sa, sb, sgn, isdiv} <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            unique case (op_in)
              OpMult, OpMultu, OpDiv, OpDivu: begin
                state       <= op_isdiv ? StDiv : StMul;
                busy        <= 1'b1;
                cnt         <= '0;
                div_by_zero <= 1'b0;
                sa          <= op_signed & a[WIDTH-1];
                sb          <= op_signed & b[WIDTH-1];
                sgn         <= op_signed;
                isdiv       <= op_isdiv;
                acc         <= '0;
                sh          <= op_isdiv ? mag_a : mag_b;
                opb         <= op_isdiv ? mag_b : mag_a;
              end
              OpMthi: begin
                hi   <= a;
                done <= 1'b1;
              end
              OpMtlo: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        StMul, StDiv: begin
          if (flush) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            if (state == StMul) begin
              acc <= add_sum[WIDTH:1];
              sh  <= {add_sum[0], sh[WIDTH-1:1]};
            end else begin
              acc <= div_rem;
              sh  <= {sh[WIDTH-2:0], div_q};
            end
            if (last) state <= StFix;
            else      cnt   <= cnt + 1'b1;
          end
        end
        StFix: begin
          state <= flush ? StIdle : StDone;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!isdiv) begin
              {hi, lo} <= prod_fix;
            end else if (opb == '0) begin
              // Remainder already equals |a|; its sign fix restores a exactly.
              hi          <= rem_fix;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: cycle-level behavioural model, directed literal cases
// and a long randomized run with flushes and resets.
module tb_alu_mdu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, flush;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int vectors = 0;
  int miscompares = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one long operation, from plain integer arithmetic.
  function automatic void calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint      sp, q, r;
    logic [63:0] up;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        up = sp;
        {h, l} = up;
      end
      3'd1: begin
        up = {32'b0, x} * {32'b0, y};
        {h, l} = up;
      end
      default: begin
        if (y == '0) begin
          h = x;
          l = '1;
          z = 1'b1;
        end else if (o == 3'd2) begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          l = q[W-1:0];
          h = r[W-1:0];
        end else begin
          l = x / y;
          h = x % y;
        end
      end
    endcase
  endfunction

  // Model state: outputs expected after the most recent rising edge.
  logic         m_valid = 1'b0;
  int           m_left, m_wait;
  logic         m_done, m_dbz, m_dbzv;
  logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
  logic         r_dbz;

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (m_done && m_dbzv) chk("div_by_zero", div_by_zero, m_dbz);
    end
    // Advance the model with the inputs the next rising edge will sample.
    if (rst_n === 1'b0) begin
      m_valid = 1'b1;
      m_left = 0; m_wait = 0; m_done = 0; m_dbz = 0; m_dbzv = 0;
      m_hi = '0; m_lo = '0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = r_hi; m_lo = r_lo; m_dbz = r_dbz; m_dbzv = 1'b1;
            m_done = 1'b1; m_wait = 1;
          end
        end
      end else if (m_wait != 0) begin
        m_wait = 0;
      end else if (start) begin
        if (op <= 3'd3) begin
          calc(op, a, b, r_hi, r_lo, r_dbz);
          m_left = W + 1;
        end else if (op == 3'd4) begin
          m_hi = a; m_done = 1'b1; m_dbzv = 1'b0;
        end else if (op == 3'd5) begin
          m_lo = a; m_done = 1'b1; m_dbzv = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz);
    int lat, nbusy;
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1; nbusy = 0;
    while (!done && lat < 200) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, W + 2);
    chk({nm, " busy cycles"}, nbusy, W + 1);
    chk({nm, " hi"}, hi, ehi);
    chk({nm, " lo"}, lo, elo);
    chk({nm, " dbz"}, div_by_zero, edbz);
    tick();
    chk({nm, " done pulse"}, done, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", busy, 0);

    run_op("mult -1*4", 3'd0, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd4, 32'h0000_0003, 32'hFFFF_FFFC, 1'b0);
    run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 7/2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("divu by 0", 3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // Ignored second start at cycle 5, flush at cycle 10.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      start = (c == 5); op = 3'd3;
      flush = (c == 10);
      tick();
    end
    start = 1'b0; flush = 1'b0;
    chk("flush busy", busy, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("flush no done", ndone, 0);
    chk("flush hi kept", hi, 32'd0);
    chk("flush lo kept", lo, 32'h8000_0000);

    // Reset in the middle of an operation.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst hi", hi, 0);
    chk("midrst lo", lo, 0);
    chk("midrst dbz", div_by_zero, 0);

    start = 1'b1; op = 3'd4; a = 32'hA5A5_A5A5;
    tick();
    start = 1'b0;
    chk("mthi hi", hi, 32'hA5A5_A5A5);
    chk("mthi done", done, 1);
    chk("mthi busy", busy, 0);
    tick();
    chk("mthi done drop", done, 0);
    chk("mthi busy after", busy, 0);

    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
      flush = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    start = 1'b0; flush = 1'b0; rst_n = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
